// File: rtl/register_array_kv.sv
// Sorted key/payload register array: head slot 0 always holds the best key,
// ties leave in arrival order, one insert/remove/replace per clock.
module register_array_kv #(
    parameter int QUEUE_SIZE = 8,
    parameter int KEY_WIDTH  = 16,
    parameter int VAL_WIDTH  = 16,
    parameter int MAX_FIRST  = 1,
    parameter int CNT_WIDTH  = $clog2(QUEUE_SIZE + 1)
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 i_wrt,
    input  logic                 i_read,
    input  logic [KEY_WIDTH-1:0] i_key,
    input  logic [VAL_WIDTH-1:0] i_val,
    output logic [KEY_WIDTH-1:0] o_key,
    output logic [VAL_WIDTH-1:0] o_val,
    output logic                 o_valid,
    output logic                 o_full,
    output logic                 o_empty,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_overflow,
    output logic                 o_underflow
);

    // Command interface: no valid/ready handshake. Every cycle i_wrt/i_read
    // form a command that is either applied at the next edge or rejected
    // with a one-cycle o_overflow/o_underflow pulse; there is never a stall.

    typedef enum logic [1:0] {
        SEL_HOLD,
        SEL_LEFT,
        SEL_RIGHT,
        SEL_NEW
    } slot_sel_e;

    logic                 v_q [QUEUE_SIZE];
    logic [KEY_WIDTH-1:0] k_q [QUEUE_SIZE];
    logic [VAL_WIDTH-1:0] d_q [QUEUE_SIZE];

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;
    logic                 full_q;
    logic                 empty_q;
    logic                 overflow_q;
    logic                 underflow_q;

    logic do_insert;
    logic do_replace;
    logic do_remove;

    logic [QUEUE_SIZE-1:0] worse;
    logic [QUEUE_SIZE+1:0] worse_ext;

    logic                 v_ext [QUEUE_SIZE+2];
    logic [KEY_WIDTH-1:0] k_ext [QUEUE_SIZE+2];
    logic [VAL_WIDTH-1:0] d_ext [QUEUE_SIZE+2];

    slot_sel_e sel [QUEUE_SIZE];

    // Replace on an empty array degenerates to a plain insert.
    assign do_insert  = i_wrt && !(i_read && !empty_q) && !full_q;
    assign do_replace = i_wrt && i_read && !empty_q;
    assign do_remove  = !i_wrt && i_read && !empty_q;

    // A slot is "worse" than the incoming key when it is empty or its key
    // loses strictly; equal keys are not worse, which keeps ties FIFO.
    always_comb begin
        for (int s = 0; s < QUEUE_SIZE; s++) begin
            if (MAX_FIRST != 0) begin
                worse[s] = !v_q[s] || (k_q[s] < i_key);
            end else begin
                worse[s] = !v_q[s] || (k_q[s] > i_key);
            end
        end
    end

    // Padded views: index s is the left neighbour of slot s, s+2 the right.
    assign worse_ext = {1'b1, worse, 1'b0};

    always_comb begin
        v_ext[0]            = 1'b0;
        k_ext[0]            = '0;
        d_ext[0]            = '0;
        v_ext[QUEUE_SIZE+1] = 1'b0;
        k_ext[QUEUE_SIZE+1] = '0;
        d_ext[QUEUE_SIZE+1] = '0;
        for (int s = 0; s < QUEUE_SIZE; s++) begin
            v_ext[s+1] = v_q[s];
            k_ext[s+1] = k_q[s];
            d_ext[s+1] = d_q[s];
        end
    end

    // Because the array is sorted, worse[] is a thermometer code; its first
    // set bit is the insert position, and replace uses the same code shifted
    // by one slot to account for the departing head.
    always_comb begin
        for (int s = 0; s < QUEUE_SIZE; s++) begin
            sel[s] = SEL_HOLD;
            if (do_insert) begin
                if (worse_ext[s+1] && !worse_ext[s]) begin
                    sel[s] = SEL_NEW;
                end else if (worse_ext[s+1]) begin
                    sel[s] = SEL_LEFT;
                end
            end else if (do_replace) begin
                if (!worse_ext[s+2]) begin
                    sel[s] = SEL_RIGHT;
                end else if ((s == 0) || !worse_ext[s+1]) begin
                    sel[s] = SEL_NEW;
                end
            end else if (do_remove) begin
                sel[s] = SEL_RIGHT;
            end
        end
    end

    always_comb begin
        count_d = count_q;
        if (do_insert) begin
            count_d = count_q + 1'b1;
        end else if (do_remove) begin
            count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int s = 0; s < QUEUE_SIZE; s++) begin
                v_q[s] <= 1'b0;
                k_q[s] <= '0;
                d_q[s] <= '0;
            end
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            for (int s = 0; s < QUEUE_SIZE; s++) begin
                unique case (sel[s])
                    SEL_LEFT: begin
                        v_q[s] <= v_ext[s];
                        k_q[s] <= k_ext[s];
                        d_q[s] <= d_ext[s];
                    end
                    SEL_RIGHT: begin
                        v_q[s] <= v_ext[s+2];
                        k_q[s] <= k_ext[s+2];
                        d_q[s] <= d_ext[s+2];
                    end
                    SEL_NEW: begin
                        v_q[s] <= 1'b1;
                        k_q[s] <= i_key;
                        d_q[s] <= i_val;
                    end
                    default: begin
                        v_q[s] <= v_q[s];
                        k_q[s] <= k_q[s];
                        d_q[s] <= d_q[s];
                    end
                endcase
            end
            count_q     <= count_d;
            full_q      <= (count_d == CNT_WIDTH'(QUEUE_SIZE));
            empty_q     <= (count_d == '0);
            overflow_q  <= i_wrt && !i_read && full_q;
            underflow_q <= !i_wrt && i_read && empty_q;
        end
    end

    assign o_key       = k_q[0];
    assign o_val       = d_q[0];
    assign o_valid     = !empty_q;
    assign o_full      = full_q;
    assign o_empty     = empty_q;
    assign o_count     = count_q;
    assign o_overflow  = overflow_q;
    assign o_underflow = underflow_q;

endmodule

// File: tb/tb_register_array_kv.sv
// Bench for register_array_kv: a max-first and a min-first instance, each
// checked every cycle against a sorted-queue model plus directed literals.
module tb_register_array_kv;

    localparam int N  = 4;
    localparam int KW = 16;
    localparam int VW = 16;
    localparam int CW = 3;

    typedef logic [31:0] q_t[$];

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST = 1'b1;
    always #5 CLK = ~CLK;

    // ---------------- DUT A: max-first ----------------
    logic          wrt_a = 1'b0, read_a = 1'b0;
    logic [KW-1:0] key_a = '0;
    logic [VW-1:0] val_a = '0;
    logic [KW-1:0] a_key;
    logic [VW-1:0] a_val;
    logic          a_valid, a_full, a_empty, a_ovf, a_unf;
    logic [CW-1:0] a_count;

    register_array_kv #(.QUEUE_SIZE(N), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_FIRST(1)) dut_a (
        .CLK(CLK), .RST(RST), .i_wrt(wrt_a), .i_read(read_a), .i_key(key_a), .i_val(val_a),
        .o_key(a_key), .o_val(a_val), .o_valid(a_valid), .o_full(a_full), .o_empty(a_empty),
        .o_count(a_count), .o_overflow(a_ovf), .o_underflow(a_unf)
    );

    // ---------------- DUT B: min-first ----------------
    logic          wrt_b = 1'b0, read_b = 1'b0;
    logic [KW-1:0] key_b = '0;
    logic [VW-1:0] val_b = '0;
    logic [KW-1:0] b_key;
    logic [VW-1:0] b_val;
    logic          b_valid, b_full, b_empty, b_ovf, b_unf;
    logic [CW-1:0] b_count;

    register_array_kv #(.QUEUE_SIZE(N), .KEY_WIDTH(KW), .VAL_WIDTH(VW), .MAX_FIRST(0)) dut_b (
        .CLK(CLK), .RST(RST), .i_wrt(wrt_b), .i_read(read_b), .i_key(key_b), .i_val(val_b),
        .o_key(b_key), .o_val(b_val), .o_valid(b_valid), .o_full(b_full), .o_empty(b_empty),
        .o_count(b_count), .o_overflow(b_ovf), .o_underflow(b_unf)
    );

    // ---------------- scoreboard ----------------
    int checks = 0;
    int errors = 0;
    bit checking = 1'b0;

    logic [31:0] exp_q_a[$];
    logic [31:0] exp_q_b[$];
    logic exp_ovf_a = 1'b0, exp_unf_a = 1'b0;
    logic exp_ovf_b = 1'b0, exp_unf_b = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Entries are {key, val}; new entry goes before the first strictly worse key.
    function automatic q_t insert_sorted(q_t q, bit max_first, logic [KW-1:0] k, logic [VW-1:0] v);
        q_t r;
        int pos;
        r = q;
        pos = r.size();
        for (int i = r.size() - 1; i >= 0; i--) begin
            if ((max_first && (r[i][31:16] < k)) || (!max_first && (r[i][31:16] > k))) begin
                pos = i;
            end
        end
        r.insert(pos, {k, v});
        return r;
    endfunction

    function automatic q_t model_next(q_t q, bit max_first, logic w, logic r, logic [KW-1:0] k,
                                      logic [VW-1:0] v);
        q_t m;
        m = q;
        if (w && r) begin
            if (m.size() > 0) void'(m.pop_front());
            m = insert_sorted(m, max_first, k, v);
        end else if (w) begin
            if (m.size() < N) m = insert_sorted(m, max_first, k, v);
        end else if (r) begin
            if (m.size() > 0) void'(m.pop_front());
        end
        return m;
    endfunction

    always @(posedge CLK) begin
        if (RST) begin
            exp_q_a = {};
            exp_q_b = {};
            exp_ovf_a = 1'b0; exp_unf_a = 1'b0;
            exp_ovf_b = 1'b0; exp_unf_b = 1'b0;
        end else begin
            exp_ovf_a = wrt_a && !read_a && (exp_q_a.size() == N);
            exp_unf_a = !wrt_a && read_a && (exp_q_a.size() == 0);
            exp_q_a   = model_next(exp_q_a, 1'b1, wrt_a, read_a, key_a, val_a);
            exp_ovf_b = wrt_b && !read_b && (exp_q_b.size() == N);
            exp_unf_b = !wrt_b && read_b && (exp_q_b.size() == 0);
            exp_q_b   = model_next(exp_q_b, 1'b0, wrt_b, read_b, key_b, val_b);
        end
    end

    task automatic compare(input string tag, input q_t q, input logic eovf, input logic eunf,
                           input logic [KW-1:0] k, input logic [VW-1:0] v, input logic valid,
                           input logic full, input logic empty, input logic [CW-1:0] cnt,
                           input logic ovf, input logic unf);
        logic [KW-1:0] ek;
        logic [VW-1:0] ev;
        ek = (q.size() > 0) ? q[0][31:16] : '0;
        ev = (q.size() > 0) ? q[0][15:0] : '0;
        check({tag, ".o_key"}, 32'(k), 32'(ek));
        check({tag, ".o_val"}, 32'(v), 32'(ev));
        check({tag, ".o_count"}, 32'(cnt), q.size());
        check({tag, ".o_valid"}, 32'(valid), 32'(q.size() > 0));
        check({tag, ".o_full"}, 32'(full), 32'(q.size() == N));
        check({tag, ".o_empty"}, 32'(empty), 32'(q.size() == 0));
        check({tag, ".o_overflow"}, 32'(ovf), 32'(eovf));
        check({tag, ".o_underflow"}, 32'(unf), 32'(eunf));
    endtask

    always @(negedge CLK) begin
        if (checking) begin
            compare("A", exp_q_a, exp_ovf_a, exp_unf_a, a_key, a_val, a_valid, a_full, a_empty,
                    a_count, a_ovf, a_unf);
            compare("B", exp_q_b, exp_ovf_b, exp_unf_b, b_key, b_val, b_valid, b_full, b_empty,
                    b_count, b_ovf, b_unf);
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive_a(input logic w, input logic r, input logic [KW-1:0] k, input logic [VW-1:0] v);
        wrt_a = w; read_a = r; key_a = k; val_a = v;
        @(posedge CLK);
        #2;
        wrt_a = 1'b0; read_a = 1'b0;
    endtask

    task automatic drive_b(input logic w, input logic r, input logic [KW-1:0] k, input logic [VW-1:0] v);
        wrt_b = w; read_b = r; key_b = k; val_b = v;
        @(posedge CLK);
        #2;
        wrt_b = 1'b0; read_b = 1'b0;
    endtask

    task automatic drive_both_random();
        wrt_a  = ($urandom_range(0, 9) < 6);
        read_a = ($urandom_range(0, 9) < 5);
        key_a  = 16'($urandom_range(0, 7));
        val_a  = 16'($urandom_range(0, 65535));
        wrt_b  = ($urandom_range(0, 9) < 6);
        read_b = ($urandom_range(0, 9) < 5);
        key_b  = 16'($urandom_range(0, 7));
        val_b  = 16'($urandom_range(0, 65535));
        @(posedge CLK);
        #2;
    endtask

    // ---------------- directed + random stimulus ----------------
    logic [KW-1:0] enq_keys [4];
    logic [KW-1:0] head_after [4];
    logic [KW-1:0] deq_keys [4];

    initial begin
        enq_keys   = '{16'd5, 16'd9, 16'd2, 16'd7};
        head_after = '{16'd5, 16'd9, 16'd9, 16'd9};
        deq_keys   = '{16'd9, 16'd7, 16'd5, 16'd2};

        RST = 1'b1;
        @(posedge CLK);
        @(posedge CLK);
        #2;
        RST = 1'b0;
        checking = 1'b1;
        check("reset.o_empty", 32'(a_empty), 32'd1);
        check("reset.o_count", 32'(a_count), 32'd0);
        check("reset.o_key", 32'(a_key), 32'd0);
        check("reset.o_valid", 32'(a_valid), 32'd0);
        idle();
        check("idle.o_overflow", 32'(a_ovf), 32'd0);
        check("idle.o_underflow", 32'(a_unf), 32'd0);

        for (int i = 0; i < 4; i++) begin
            drive_a(1'b1, 1'b0, enq_keys[i], 16'(i));
            check("enq.head", 32'(a_key), 32'(head_after[i]));
        end
        check("enq.full", 32'(a_full), 32'd1);
        drive_a(1'b1, 1'b0, 16'd1, 16'h11);
        check("full_enq.overflow", 32'(a_ovf), 32'd1);
        check("full_enq.count", 32'(a_count), 32'd4);
        idle();
        check("overflow.pulse_end", 32'(a_ovf), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("deq.order", 32'(a_key), 32'(deq_keys[i]));
            drive_a(1'b0, 1'b1, '0, '0);
        end
        check("deq.empty", 32'(a_empty), 32'd1);

        drive_a(1'b1, 1'b0, 16'd4, 16'hA);
        drive_a(1'b1, 1'b0, 16'd4, 16'hB);
        drive_a(1'b1, 1'b0, 16'd4, 16'hC);
        check("tie.val0", 32'(a_val), 32'hA);
        drive_a(1'b0, 1'b1, '0, '0);
        check("tie.val1", 32'(a_val), 32'hB);
        drive_a(1'b0, 1'b1, '0, '0);
        check("tie.val2", 32'(a_val), 32'hC);
        drive_a(1'b0, 1'b1, '0, '0);

        drive_a(1'b1, 1'b0, 16'd9, 16'h90);
        drive_a(1'b1, 1'b0, 16'd7, 16'h70);
        drive_a(1'b1, 1'b0, 16'd5, 16'h50);
        drive_a(1'b1, 1'b0, 16'd2, 16'h20);
        drive_a(1'b1, 1'b1, 16'd8, 16'h80);
        check("replace8.head", 32'(a_key), 32'd8);
        check("replace8.count", 32'(a_count), 32'd4);
        drive_a(1'b1, 1'b1, 16'd1, 16'h10);
        check("replace1.head", 32'(a_key), 32'd7);
        deq_keys = '{16'd7, 16'd5, 16'd2, 16'd1};
        for (int i = 0; i < 4; i++) begin
            check("replace.contents", 32'(a_key), 32'(deq_keys[i]));
            drive_a(1'b0, 1'b1, '0, '0);
        end
        drive_a(1'b1, 1'b1, 16'd3, 16'h30);
        check("replace_empty.count", 32'(a_count), 32'd1);
        check("replace_empty.head", 32'(a_key), 32'd3);
        check("replace_empty.underflow", 32'(a_unf), 32'd0);

        drive_b(1'b1, 1'b0, 16'd5, 16'h5);
        drive_b(1'b1, 1'b0, 16'd9, 16'h9);
        drive_b(1'b1, 1'b0, 16'd2, 16'h2);
        check("min.head", 32'(b_key), 32'd2);
        deq_keys = '{16'd2, 16'd5, 16'd9, 16'd0};
        for (int i = 0; i < 3; i++) begin
            check("min.order", 32'(b_key), 32'(deq_keys[i]));
            drive_b(1'b0, 1'b1, '0, '0);
        end
        drive_b(1'b0, 1'b1, '0, '0);
        check("min.underflow", 32'(b_unf), 32'd1);
        check("min.count", 32'(b_count), 32'd0);
        idle();
        check("underflow.pulse_end", 32'(b_unf), 32'd0);

        drive_a(1'b1, 1'b0, 16'd10, 16'hA0);
        drive_a(1'b1, 1'b0, 16'd6, 16'h60);
        check("pre_reset.count", 32'(a_count), 32'd3);
        RST = 1'b1;
        drive_a(1'b1, 1'b0, 16'd50, 16'h55);
        RST = 1'b0;
        check("mid_reset.count", 32'(a_count), 32'd0);
        check("mid_reset.empty", 32'(a_empty), 32'd1);
        check("mid_reset.key", 32'(a_key), 32'd0);
        check("mid_reset.val", 32'(a_val), 32'd0);
        check("mid_reset.valid", 32'(a_valid), 32'd0);

        for (int i = 0; i < 400; i++) begin
            RST = ($urandom_range(0, 59) == 0);
            drive_both_random();
        end
        RST = 1'b0;
        wrt_a = 1'b0; read_a = 1'b0; wrt_b = 1'b0; read_b = 1'b0;
        idle();
        idle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
